// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file and its port arbiters.
//   RF_ADDR_WIDTH / RF_DATA_WIDTH : default reg_file geometry
//   idx_width()                   : bits needed to index n items (minimum 1)
package reg_file_pkg;

    localparam int RF_ADDR_WIDTH = 8;
    localparam int RF_DATA_WIDTH = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_file_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from start
// upward, wrapping modulo N.
//   req   : request vector
//   start : index to begin scanning at (must be < N)
//   grant : one-hot winner, zero when nothing requests
//   found : any request present
module rr_pick
    import reg_file_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          found
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Shares the single reg_file write port among NUM_REQ requesters using
// round-robin with an optional burst hold of up to BURST_LEN beats.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/addr/data    : per-requester write requests (flattened slices)
//   req_ready              : combinational one-hot grant, accept = valid & ready
//   rf_write/_addr/_data   : registered write to reg_file, one cycle after accept
//   busy                   : registered, any req_valid seen last cycle
module reg_file_wr_arbiter
    import reg_file_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int BURST_LEN  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_write,
    output logic [ADDR_WIDTH-1:0]         rf_write_addr,
    output logic [DATA_WIDTH-1:0]         rf_write_data,
    output logic                          busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = idx_width(BURST_LEN + 1);

    logic                 owner_valid;
    logic [IW-1:0]        owner;
    logic [CW-1:0]        burst_cnt;
    logic [IW-1:0]        ptr;
    logic                 write_q;

    logic [NUM_REQ-1:0]   scan_grant;
    logic                 scan_found;
    logic                 hold;
    logic [NUM_REQ-1:0]   hold_oh;
    logic [NUM_REQ-1:0]   win_oh;
    logic [IW-1:0]        win_idx;
    logic                 accept;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .start (ptr),
        .grant (scan_grant),
        .found (scan_found)
    );

    // The current owner keeps the port while it still has budget left.
    assign hold = owner_valid && req_valid[owner] && (burst_cnt < CW'(BURST_LEN));

    always_comb begin
        hold_oh        = '0;
        hold_oh[owner] = 1'b1;
        win_oh         = hold ? hold_oh : scan_grant;
        accept         = !reset && (hold || scan_found);
        req_ready      = accept ? win_oh : '0;
        win_idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = IW'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q       <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            busy          <= 1'b0;
            owner_valid   <= 1'b0;
            owner         <= '0;
            burst_cnt     <= '0;
            ptr           <= '0;
        end else begin
            busy <= |req_valid;
            if (accept) begin
                write_q       <= 1'b1;
                rf_write_addr <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                rf_write_data <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                owner_valid   <= 1'b1;
                if (owner_valid && win_idx == owner) begin
                    // Saturate: a sole requester can keep winning via the
                    // scan after its budget is spent; the counter must not wrap.
                    if (burst_cnt < CW'(BURST_LEN)) burst_cnt <= burst_cnt + CW'(1);
                end else begin
                    owner     <= win_idx;
                    burst_cnt <= CW'(1);
                end
                ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
            end else begin
                write_q     <= 1'b0;
                owner_valid <= 1'b0;
                burst_cnt   <= '0;
            end
        end
    end

    // A beat registered just before reset is dropped in the reset cycle
    // itself so reg_file never commits it.
    assign rf_write = write_q & ~reset;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
module tb_reg_file_wr_arbiter;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  vld [2];
    logic [31:0] abus [2];
    logic [31:0] dbus [2];
    logic [3:0]  rdy [2];
    logic        wr [2];
    logic [7:0]  wa [2];
    logic [7:0]  wd [2];
    logic        bsy [2];

    always #5 clock = ~clock;

    reg_file_wr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_LEN(1)) u_rr (
        .clock(clock), .reset(reset), .req_valid(vld[0]), .req_addr(abus[0]),
        .req_data(dbus[0]), .req_ready(rdy[0]), .rf_write(wr[0]),
        .rf_write_addr(wa[0]), .rf_write_data(wd[0]), .busy(bsy[0]));

    reg_file_wr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_LEN(2)) u_bu (
        .clock(clock), .reset(reset), .req_valid(vld[1]), .req_addr(abus[1]),
        .req_data(dbus[1]), .req_ready(rdy[1]), .rf_write(wr[1]),
        .rf_write_addr(wa[1]), .rf_write_data(wd[1]), .busy(bsy[1]));

    // reg_file stand-ins fed from the DUT write ports
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    always @(posedge clock) if (wr[0] === 1'b1) mem0[wa[0]] <= wd[0];
    always @(posedge clock) if (wr[1] === 1'b1) mem1[wa[1]] <= wd[1];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model: pending requests plus arbitration state per instance
    int         bl [2] = '{1, 2};
    bit         pv [2][4];
    logic [7:0] pa [2][4];
    logic [7:0] pd [2][4];
    bit         refill [4];
    bit         ov [2];
    int         own [2];
    int         cnt [2];
    int         ptr [2];
    bit         ewr [2];
    logic [7:0] ea [2];
    logic [7:0] ed [2];
    bit         ebusy [2];
    int         dwin [2];

    function automatic int model_win(input int k);
        if (ov[k] && pv[k][own[k]] && cnt[k] < bl[k]) return own[k];
        for (int s = 0; s < N; s++) begin
            if (pv[k][(ptr[k] + s) % N]) return (ptr[k] + s) % N;
        end
        return -1;
    endfunction

    function automatic int decode(input logic [3:0] r);
        if ($countones(r) == 0) return -1;
        if ($countones(r) > 1) return -2;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ov[k] = 0; own[k] = 0; cnt[k] = 0; ptr[k] = 0;
            ewr[k] = 0; ea[k] = 0; ed[k] = 0; ebusy[k] = 0;
        end
    endtask

    task automatic put(input int i, input logic [7:0] a, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            pv[k][i] = 1; pa[k][i] = a; pd[k][i] = d;
        end
    endtask

    // One clock: drive, check combinational grant and registered outputs,
    // then advance the model across the edge.
    task automatic step(input bit rst);
        int w [2];
        logic [3:0] er;
        reset = rst;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                vld[k][i] = pv[k][i];
                abus[k][i*8 +: 8] = pa[k][i];
                dbus[k][i*8 +: 8] = pd[k][i];
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            w[k] = rst ? -1 : model_win(k);
            er = '0;
            if (w[k] >= 0) er[w[k]] = 1'b1;
            dwin[k] = decode(rdy[k]);
            chk($sformatf("u%0d_ready", k), rdy[k], er);
            chk($sformatf("u%0d_wr", k), wr[k], ewr[k] & ~rst);
            chk($sformatf("u%0d_addr", k), wa[k], ea[k]);
            chk($sformatf("u%0d_data", k), wd[k], ed[k]);
            chk($sformatf("u%0d_busy", k), bsy[k], ebusy[k]);
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ov[k] = 0; own[k] = 0; cnt[k] = 0; ptr[k] = 0;
                ewr[k] = 0; ea[k] = 0; ed[k] = 0; ebusy[k] = 0;
            end else begin
                ebusy[k] = 0;
                for (int i = 0; i < N; i++) if (pv[k][i]) ebusy[k] = 1;
                if (w[k] >= 0) begin
                    ewr[k] = 1; ea[k] = pa[k][w[k]]; ed[k] = pd[k][w[k]];
                    if (ov[k] && w[k] == own[k]) cnt[k]++;
                    else begin own[k] = w[k]; cnt[k] = 1; end
                    ov[k] = 1;
                    ptr[k] = (w[k] + 1) % N;
                    pv[k][w[k]] = refill[w[k]];
                    pa[k][w[k]] = 8'($urandom);
                    pd[k][w[k]] = 8'($urandom);
                end else begin
                    ewr[k] = 0; ov[k] = 0; cnt[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int r = 0; r < N; r++) refill[r] = 0;
        for (int c = 0; c < 20; c++) step(0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                chk("drained", 32'(pv[k][i]), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                pv[k][i] = 0; pa[k][i] = 0; pd[k][i] = 0;
            end
            vld[k] = '0; abus[k] = '0; dbus[k] = '0;
        end
        for (int i = 0; i < N; i++) refill[i] = 0;
        reset = 1;
        @(posedge clock); #1;
        model_reset();

        // Reset held with everyone requesting; req0 wins first afterwards
        for (int i = 0; i < N; i++) put(i, 8'(i), 8'(16 + i));
        step(1); step(1);
        step(0);
        chk("first_u0", dwin[0], 0);
        chk("first_u1", dwin[1], 0);
        drain();

        // Single requester, same-cycle ready, next-cycle write
        put(2, 8'd10, 8'b01010101);
        step(0);
        for (int k = 0; k < 2; k++) begin
            chk("solo_ready", dwin[k], 2);
            chk("solo_wr", wr[k], 1);
            chk("solo_addr", wa[k], 10);
            chk("solo_data", wd[k], 8'h55);
        end
        step(0);
        chk("solo_mem0", mem0[10], 8'h55);
        chk("solo_mem1", mem1[10], 8'h55);

        // All four continuously valid from ptr=0
        step(1);
        for (int i = 0; i < N; i++) begin put(i, 8'(32 + i), 8'($urandom)); refill[i] = 1; end
        for (int c = 0; c < 8; c++) begin
            step(0);
            chk("rr_order", dwin[0], c % 4);
            chk("burst_order", dwin[1], (c / 2) % 4);
            if (c > 0) begin
                chk("rr_stream", wr[0], 1);
                chk("burst_stream", wr[1], 1);
            end
        end
        drain();

        // Two continuous requesters
        step(1);
        put(0, 8'd1, 8'd1); put(1, 8'd2, 8'd2);
        refill[0] = 1; refill[1] = 1;
        for (int c = 0; c < 6; c++) begin
            step(0);
            chk("two_rr", dwin[0], c % 2);
            chk("two_burst", dwin[1], (c / 2) % 2);
        end
        drain();

        // Owner drops after one beat: no gap, req1 continues
        step(1);
        put(0, 8'd3, 8'd3); put(1, 8'd4, 8'd4);
        refill[1] = 1;
        step(0); chk("drop_a", dwin[1], 0);
        step(0); chk("drop_b", dwin[1], 1);
        step(0); chk("drop_c", dwin[1], 1);
        chk("drop_nogap", wr[1], 1);
        drain();

        // Same-address collision resolved in grant order
        step(1);
        put(1, 8'd15, 8'hFF); put(3, 8'd15, 8'h00);
        step(0); chk("col_first", dwin[0], 1);
        step(0); chk("col_second", dwin[0], 3);
        step(0);
        chk("col_mem0", mem0[15], 8'h00);
        chk("col_mem1", mem1[15], 8'h00);

        // Reset in the cycle after an accept loses that beat
        put(0, 8'd11, 8'hA5);
        step(0); step(0); step(0);
        put(0, 8'd11, 8'h05);
        step(0);
        step(1);
        chk("rst_lost_wr", wr[0], 0);
        step(0);
        chk("rst_lost_mem0", mem0[11], 8'hA5);
        chk("rst_lost_mem1", mem1[11], 8'hA5);
        put(0, 8'd20, 8'd20); put(3, 8'd21, 8'd21);
        step(0);
        chk("rst_restart", dwin[0], 0);
        drain();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N; i++)
                    if (!pv[k][i] && $urandom_range(0, 99) < 45) begin
                        pv[k][i] = 1; pa[k][i] = 8'($urandom); pd[k][i] = 8'($urandom);
                    end
            step($urandom_range(0, 99) < 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_wr_arbiter.md
Name: reg_file_wr_arbiter

Overview:
Shares the single write port of reg_file among NUM_REQ independent requesters.
- Uses valid/ready per requester and round-robin priority with optional burst hold.
- Output is registered and drives reg_file's write, write_addr and write_data inputs directly.
- Sits between producer units (ALU writeback, load unit, etc.) and the reg_file instance.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- ADDR_WIDTH, 8: register address width; must match reg_file.
- DATA_WIDTH, 8: register data width; must match reg_file.
- BURST_LEN, 1: max consecutive beats one owner may win while others wait, ≥1. 1 gives pure round-robin.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  flattened; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; combinational grant, accepted when valid&ready.
- rf_write  out  1  registered write enable to reg_file.
- rf_write_addr  out  ADDR_WIDTH  registered write address to reg_file.
- rf_write_data  out  DATA_WIDTH  registered write data to reg_file.
- busy  out  1  registered; 1 when any req_valid was high in the previous cycle.

Behaviour:
- Reset, synchronous, clock edge with reset=1:
  - rf_write=0, rf_write_addr=0, rf_write_data=0, busy=0.
  - owner=none, burst_cnt=0, search pointer=0.
  - While reset=1, req_ready is forced to 0.
- State:
  - owner: index of last accepted requester, plus an owner_valid flag.
  - burst_cnt: beats accepted by owner, range 1..BURST_LEN.
  - ptr: next round-robin start index.
- Grant, combinational each cycle:
  - If owner_valid, req_valid[owner]=1 and burst_cnt<BURST_LEN, the winner is owner (hold).
  - Otherwise the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - No valid requester means req_ready=0.
- Update on accept, clock edge:
  - rf_write_addr/rf_write_data ← winner's slice; rf_write ← 1.
  - If winner==owner, burst_cnt+1; else owner←winner and burst_cnt←1.
  - ptr←(winner+1) mod NUM_REQ, wrapping at NUM_REQ-1→0.
- No accept in a cycle: rf_write←0; addr/data hold their last value; owner_valid←0; burst_cnt←0.
- Latency: accept in cycle N gives rf_write=1 in cycle N+1. reg_file commits at the end of N+1.
- Throughput: one write per cycle. There are no idle cycles when another requester is valid, including when the owner drops valid mid-burst.
- Requesters must hold valid/addr/data stable until accepted. The arbiter never drops an accepted beat except on reset.
- Same-address writes from different requesters serialize in grant order; the last granted value persists.
- Reset in cycle N+1 after an accept in N: the registered write is cleared (rf_write=0) and that beat is lost. This is documented and expected.
- Starvation bound: a valid requester is granted within (NUM_REQ-1)*BURST_LEN cycles.

Decomposition:
- reg_file_pkg:
  - default ADDR_WIDTH/DATA_WIDTH constants shared with reg_file.
  - clog2-based index-width function for owner/ptr.
- Sub-module rr_pick, combinational: inputs req vector and start index; outputs one-hot grant and found flag. Reusable by a future read-port arbiter.
- The top holds the owner/burst/ptr registers and the output register stage.

Test Plan:
- Reset held 2 cycles with all req_valid=1: req_ready=0, rf_write=0, rf_write_addr=0, rf_write_data=0 throughout. After release, req0 is granted first.
- req2 only, addr 8'd10, data 8'b01010101: req_ready[2]=1 the same cycle; next cycle rf_write=1, addr 10, data 0x55. reg_file r1_addr=10 then reads 8'b01010101.
- BURST_LEN=1, all four requesters valid for 8 cycles: grant order 0,1,2,3,0,1,2,3. rf_write stays high continuously.
- BURST_LEN=2, req0 and req1 continuously valid: grant order 0,0,1,1,0,0. With req0 dropping valid after 1 beat, the order is 0,1,1 with no gap.
- Collision: req1 {addr 15, data 8'hFF} and req3 {addr 15, data 8'h00} valid together from ptr=0: writes occur in order FF then 00, and reg_file[15] reads 8'h00.
- Reset asserted the cycle after accepting req0 {addr 11, data 8'h05}: rf_write=0 that cycle, reg_file[11] is unchanged, and the next grant starts from req0.
